// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared definitions for the RAM arbiter and its grant selector.
//   state_t      - arbiter FSM encoding (IDLE, ACCESS, RESP), 2 bits
//   REQ_I/REQ_D  - requester IDs as driven on grant_d
//   CNT_W        - width of the latency and starvation counters
package cpu_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/ram_arb_select.sv
// ram_arb_select: grant decision between fetch (I) and memory-stage (D)
// requesters, with a starvation counter that forces I to win after
// STARVE_LIMIT consecutive D grants taken while I was waiting.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   if_req       - fetch request pending
//   d_req        - data request pending
//   grant_stb    - high when the arbiter is free to grant this cycle
//   grant_valid  - some requester can be granted
//   grant_d      - winner (1 = D, 0 = I); meaningful with grant_valid
module ram_arb_select
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_stb,
  output logic grant_valid,
  output logic grant_d
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             below_limit;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_d     = REQ_I;
    below_limit = (starve_cnt < LIMIT);
    if (d_req && (!if_req || below_limit)) begin
      grant_valid = 1'b1;
      grant_d     = REQ_D;
    end else if (if_req) begin
      grant_valid = 1'b1;
      grant_d     = REQ_I;
    end
  end

  // Counts D grants that bypassed a waiting I; saturates at the limit so the
  // comparison above stays pinned until I is finally served.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_stb && grant_valid) begin
      if (grant_d == REQ_D && if_req) begin
        if (below_limit) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-ported RAM between the fetch requester (I)
// and the memory-stage requester (D). One transaction at a time:
// IDLE (sample requests) -> ACCESS (1 cycle for writes, LATENCY for reads)
// -> RESP (one-cycle done pulse to the owner) -> IDLE.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   if_req/if_addr             - fetch read request and address
//   if_rdata/if_done           - fetch data (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata  - data request, store flag, address, data
//   d_rdata/d_done             - load data (held) and completion pulse
//   ram_addr/ram_wdata/ram_we  - registered RAM command
//   ram_rdata                  - RAM read data
//   busy                       - any state other than IDLE
//   grant_d                    - owner of current transaction (1 = D)
module ram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        busy,
  output logic        grant_d
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             grant_stb;
  logic             sel_valid;
  logic             sel_d;
  logic             read_last;

  assign grant_stb = (state == ST_IDLE);
  assign read_last = (lat_cnt == LAT_LAST);

  ram_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_stb   (grant_stb),
    .grant_valid (sel_valid),
    .grant_d     (sel_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the state-decoded outputs. Done pulses come straight
  // from RESP so they can never outlive the transaction.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    if_done   = 1'b0;
    d_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_valid) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A store needs only the single write cycle; a load waits out the
        // RAM latency.
        if (ram_we || read_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if_done   = (grant_d == REQ_I);
        d_done    = (grant_d == REQ_D);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command and response registers. The read data registers are reset as
  // well because their value is visible to the pipeline at all times.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      grant_d   <= REQ_I;
      lat_cnt   <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            grant_d <= sel_d;
            lat_cnt <= '0;
            if (sel_d == REQ_D) begin
              ram_addr  <= d_addr;
              ram_wdata <= d_wdata;
              ram_we    <= d_we;
            end else begin
              // Fetches never write; ram_wdata keeps its last value.
              ram_addr <= if_addr;
              ram_we   <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (ram_we) begin
            ram_we <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
            if (read_last) begin
              if (grant_d == REQ_D) d_rdata  <= ram_rdata;
              else                  if_rdata <= ram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the single-ported RAM between the instruction-fetch requester (port I) and the memory-stage requester (port D).
- Each requester holds a request until the arbiter returns a one-cycle done pulse; the arbiter owns the RAM address, write data and write enable.
- Sits between the fetch and memory stages and the RAM model. Pipeline stall logic uses the done/busy outputs.

Parameters:
- LATENCY, 1, RAM read latency in cycles from address presented to ram_rdata valid (legal range 1..15).
- STARVE_LIMIT, 4, consecutive D grants allowed while if_req is pending before I is forced to win (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch read request; held high until if_done
- if_addr  input  32  fetch address; stable while if_req is high
- if_rdata  output  32  fetch read data; valid in the if_done cycle, held until next I completion
- if_done  output  1  one-cycle completion pulse for port I
- d_req  input  1  data request; held high until d_done
- d_we  input  1  1 = store, 0 = load; stable while d_req is high
- d_addr  input  32  data address; stable while d_req is high
- d_wdata  input  32  store data; stable while d_req is high
- d_rdata  output  32  load data; valid in the d_done cycle, held until next D load completion
- d_done  output  1  one-cycle completion pulse for port D
- ram_addr  output  32  registered address to RAM
- ram_wdata  output  32  registered write data to RAM
- ram_we  output  1  RAM write enable
- ram_rdata  input  32  RAM read data
- busy  output  1  high in any state other than IDLE
- grant_d  output  1  owner of the current transaction (1 = D, 0 = I); meaningful only while busy

Behaviour:
- Reset (synchronous, rst high at a rising edge) applies from any state, including mid-transaction:
  - state = IDLE.
  - ram_addr, ram_wdata, if_rdata and d_rdata = 0.
  - ram_we, if_done, d_done, busy and grant_d = 0.
  - Latency counter and starvation counter = 0.
  - The aborted transaction gets no done pulse.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If d_req and (not if_req, or starve_cnt < STARVE_LIMIT): grant D.
  - Otherwise, if if_req: grant I.
  - If neither is requesting: remain in IDLE.
  - On a grant: latch addr, wdata and we (we forced to 0 for I) into ram_addr, ram_wdata and ram_we; set grant_d; go to ACCESS; latency counter = 0.
- Starvation counter:
  - Incremented on a D grant while if_req is high.
  - Cleared on an I grant, and on a D grant while if_req is low.
  - Saturates at STARVE_LIMIT.
- ACCESS, write transaction (ram_we = 1):
  - Stays exactly 1 cycle.
  - ram_we drops to 0 on exit.
  - Goes to RESP.
- ACCESS, read transaction:
  - Stays LATENCY cycles; counter increments each cycle.
  - At the edge ending the LATENCY-th ACCESS cycle, capture ram_rdata into if_rdata or d_rdata according to grant_d, then go to RESP.
- RESP:
  - Lasts exactly 1 cycle.
  - The owner's done = 1 in this cycle; the other port's done stays 0.
  - Goes to IDLE.
  - busy = 1 in this cycle and drops with the transition to IDLE.
- Latency from a request seen in IDLE cycle 0 to the done pulse:
  - Reads: done in cycle LATENCY+1.
  - Writes: done in cycle 1 + 1 = 2.
  - Minimum turnaround between back-to-back grants: LATENCY+2 cycles.
- Requester contract:
  - Deassert req, or present a new request, in the cycle after done.
  - A req still high in the following IDLE cycle is a new transaction.
- ram_addr and ram_wdata hold their last values outside ACCESS; only ram_we is qualified.
- No byte enables and no alignment checks: addresses pass through unchanged.
- Simultaneous if_req and d_req in IDLE: D wins unless starve_cnt == STARVE_LIMIT.
- Input changes while not in IDLE are ignored.

Decomposition:
- Shared package (cpu_mem_pkg):
  - State encoding constants ST_IDLE, ST_ACCESS, ST_RESP (2-bit).
  - Requester IDs REQ_I = 0, REQ_D = 1.
  - Counter width constant CNT_W = 4.
- One natural sub-module, ram_arb_select: combinational grant decision plus the registered starvation counter (inputs: if_req, d_req, a grant strobe; outputs: grant_valid, grant_d).
- FSM, latency counter and datapath registers stay in ram_arbiter.

Test Plan:
- Reset mid-read: D load granted, assert rst on ACCESS cycle 1 -> next cycle state IDLE, ram_we = 0, busy = 0, d_done never pulses, d_rdata = 0.
- Single fetch, LATENCY = 3: if_req with if_addr = 0x0000_0040, RAM returns 0x0051_3093 -> ram_addr = 0x40 from cycle 1, if_done high only in cycle 4, if_rdata = 0x0051_3093.
- Single store: d_req, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF -> ram_we high for exactly 1 cycle with ram_addr = 0x100 and ram_wdata = 0xDEAD_BEEF, d_done in cycle 2, if_done stays 0.
- Simultaneous requests: if_req and d_req asserted together with starve_cnt = 0 -> D is served first (grant_d = 1), then I on the next IDLE; if_rdata and d_rdata each match their own addresses.
- Starvation, STARVE_LIMIT = 2: if_req held continuously, d_req reasserted after every d_done -> grant order D, D, I, D, D, I.
- Back-to-back loads, LATENCY = 1: D issues loads to 0x10 then 0x14 -> d_done pulses 3 cycles apart; d_rdata updates only at each pulse and holds between them.
